nn_weight_demux: RTL

Sequential 1-to-N demultiplexer/loader for the neural network datapath. It accepts a stream of 4-bit words over a valid/ready handshake and steers word k of each frame into holding register k. It then signals frame completion, so that downstream neuron lanes receive one parallel set of operands. It is the distribution side of the datapath, opposite to the N-to-1 selection muxes.

---
 rtl/nn_pkg.sv | 14 +
 rtl/nn_lane_reg.sv | 34 +++
 rtl/nn_weight_demux.sv | 95 +++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared neural-datapath types: word width, word typedef and loader FSM states.
package nn_pkg;

    localparam int NN_DATA_W = 4;

    typedef logic [NN_DATA_W-1:0] nn_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/nn_lane_reg.sv
// One lane holding register with load enable and a registered load strobe.
module nn_lane_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              load_strobe
);

    logic [DATA_W-1:0] data_r;
    logic              strobe_r;

    // Capture the word on load; strobe echoes the load one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r   <= {DATA_W{1'b0}};
            strobe_r <= 1'b0;
        end else begin
            strobe_r <= load_en;
            if (load_en) begin
                data_r <= d;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign q           = data_r;
    assign load_strobe = strobe_r;

endmodule

// File: rtl/nn_weight_demux.sv
// Sequential 1-to-LANES loader: steers word k of each frame into lane register k,
// then pulses frame_done for one cycle.
module nn_weight_demux
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int LANES  = 4,
    parameter int IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANES*DATA_W-1:0] lane_data,
    output logic [LANES-1:0]        lane_load,
    output logic                    frame_done,
    output logic                    busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    ld_state_t        state_r;
    logic [IDX_W-1:0] idx_r;
    logic             accept_s;
    logic [LANES-1:0] lane_en_s;

    // Status outputs decode the state register only, so in_valid never reaches in_ready.
    assign in_ready   = (state_r == LOAD);
    assign frame_done = (state_r == DONE);
    assign busy       = (state_r != IDLE);
    assign accept_s   = in_valid & in_ready;

    // One-hot lane enable from the current index, gated by the handshake.
    always_comb begin
        lane_en_s = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (accept_s && (idx_r == IDX_W'(k))) begin
                lane_en_s[k] = 1'b1;
            end else begin
                lane_en_s[k] = 1'b0;
            end
        end
    end

    // Frame sequencer; the LAST_IDX compare ends the frame so idx never reaches LANES.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= LOAD;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                            idx_r   <= {IDX_W{1'b0}};
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nn_lane_reg #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_en    (lane_en_s[g]),
            .d          (in_data),
            .q          (lane_data[g*DATA_W +: DATA_W]),
            .load_strobe(lane_load[g])
        );
    end

endmodule
